// File: rtl/dec_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// dec_dispatch_pkg : shared types and widths for the decode dispatch slice
// Rev 1.0
// ============================================================================
package dec_dispatch_pkg;

  localparam int DEF_INS       = 32;
  localparam int DEF_QDEPTH    = 8;
  localparam int DEF_ROB_DEPTH = 16;

  localparam int QW        = $clog2(DEF_QDEPTH) + 1;
  localparam int CW        = $clog2(DEF_ROB_DEPTH + 1);
  localparam int MAX_ISSUE = 2;

  typedef struct packed {
    logic [DEF_INS-1:0] ins;
    logic [DEF_INS-1:0] pc;
  } ins_entry_t;

endpackage
`default_nettype wire

// File: rtl/dec_dispatch_if.sv
`default_nettype none
// ============================================================================
// ifc_rob_dec : two-wide decode-to-ROB instruction interface
// Rev 1.0
// ============================================================================
interface ifc_rob_dec
  import dec_dispatch_pkg::*;
#(
  parameter int INS = DEF_INS
);
  logic           ins1_valid;
  logic [INS-1:0] ins1;
  logic [INS-1:0] PC1;
  logic           ins2_valid;
  logic [INS-1:0] ins2;
  logic [INS-1:0] PC2;

  modport dec (output ins1_valid, ins1, PC1, ins2_valid, ins2, PC2);
  modport rob (input  ins1_valid, ins1, PC1, ins2_valid, ins2, PC2);
endinterface
`default_nettype wire

// File: rtl/dec_dispatch_queue.sv
`default_nettype none
// ============================================================================
// ins_queue_2w : circular buffer, up to two writes and two reads per cycle
// Rev 1.0
// ============================================================================
module ins_queue_2w
  import dec_dispatch_pkg::*;
#(
  parameter type T     = ins_entry_t,
  parameter int  DEPTH = DEF_QDEPTH
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   flush_i,
  input  wire logic                   wr1_i,
  input  wire logic                   wr2_i,
  input  wire T                       wdata1_i,
  input  wire T                       wdata2_i,
  input  wire logic [1:0]             rd_n_i,
  output T                            head0_o,
  output T                            head1_o,
  output logic [$clog2(DEPTH):0]      count_o
);
  localparam int AW = $clog2(DEPTH);

  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            w_wr2;
  logic [1:0]      w_enq;

  // Slot 2 is only ever written behind slot 1.
  assign w_wr2 = wr1_i & wr2_i;
  assign w_enq = {1'b0, wr1_i} + {1'b0, w_wr2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(w_enq);
      rd_ptr_q <= rd_ptr_q + AW'(rd_n_i);
      count_q  <= count_q + (AW+1)'(w_enq) - (AW+1)'(rd_n_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (wr1_i) mem_q[wr_ptr_q]           <= wdata1_i;
      if (w_wr2) mem_q[wr_ptr_q + AW'(1)]  <= wdata2_i;
    end
  end

  assign head0_o = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr_q + AW'(1)];
  assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/dec_dispatch.sv
`default_nettype none
// ============================================================================
// dec_dispatch : decode-side transmitter, queue + credit-throttled 2-wide issue
// Rev 1.0
// ============================================================================
module dec_dispatch
  import dec_dispatch_pkg::*;
#(
  parameter int INS       = DEF_INS,
  parameter int QDEPTH    = DEF_QDEPTH,
  parameter int ROB_DEPTH = DEF_ROB_DEPTH
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    flush,
  input  wire logic                    f_valid1,
  input  wire logic [INS-1:0]          f_ins1,
  input  wire logic [INS-1:0]          f_pc1,
  input  wire logic                    f_valid2,
  input  wire logic [INS-1:0]          f_ins2,
  input  wire logic [INS-1:0]          f_pc2,
  output logic                         f_ready,
  input  wire logic [1:0]              rob_retire_cnt,
  ifc_rob_dec.dec                      rob_dec_if,
  output logic [$clog2(QDEPTH):0]      q_count
);
  localparam int CNT_W  = $clog2(QDEPTH) + 1;
  localparam int CRED_W = $clog2(ROB_DEPTH + 1);

  if (INS != DEF_INS || QDEPTH < 4 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_param_check
    $error("dec_dispatch: unsupported parameter set");
  end

  ins_entry_t          w_head0, w_head1;
  logic [CNT_W-1:0]    w_count;
  logic                w_wr1;
  logic [1:0]          w_n;
  logic [CRED_W:0]     w_cred_sum;
  logic [CRED_W-1:0]   credits_q, credits_d;
  logic                ins1_valid_q, ins2_valid_q;
  ins_entry_t          slot1_q, slot2_q;

  // Readiness comes from the registered count only, so a full queue stays
  // closed even in a cycle where it also drains.
  assign f_ready = (w_count <= CNT_W'(QDEPTH - 2));
  assign w_wr1   = f_ready & f_valid1;

  ins_queue_2w #(.T(ins_entry_t), .DEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush),
    .wr1_i    (w_wr1),
    .wr2_i    (f_valid2),
    .wdata1_i ({f_ins1, f_pc1}),
    .wdata2_i ({f_ins2, f_pc2}),
    .rd_n_i   (w_n),
    .head0_o  (w_head0),
    .head1_o  (w_head1),
    .count_o  (w_count)
  );

  always_comb begin
    w_n = 2'(MAX_ISSUE);
    if (w_count < CNT_W'(2)) w_n = w_count[1:0];
    if ({{(CRED_W-2){1'b0}}, w_n} > credits_q) w_n = credits_q[1:0];
  end

  assign w_cred_sum = {1'b0, credits_q} + (CRED_W+1)'(rob_retire_cnt);
  assign credits_d  = CRED_W'(w_cred_sum - (CRED_W+1)'(w_n));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q    <= CRED_W'(ROB_DEPTH);
      ins1_valid_q <= 1'b0;
      ins2_valid_q <= 1'b0;
      slot1_q      <= '0;
      slot2_q      <= '0;
    end else if (flush) begin
      credits_q    <= CRED_W'(ROB_DEPTH);
      ins1_valid_q <= 1'b0;
      ins2_valid_q <= 1'b0;
      slot1_q      <= '0;
      slot2_q      <= '0;
    end else begin
      credits_q    <= credits_d;
      ins1_valid_q <= (w_n != 2'd0);
      ins2_valid_q <= (w_n == 2'd2);
      slot1_q      <= (w_n != 2'd0) ? w_head0 : '0;
      slot2_q      <= (w_n == 2'd2) ? w_head1 : '0;
    end
  end

  // Retiring more than was ever dispatched is a ROB protocol violation.
  a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
    !flush |-> (w_cred_sum - (CRED_W+1)'(w_n)) <= (CRED_W+1)'(ROB_DEPTH));

  assign rob_dec_if.ins1_valid = ins1_valid_q;
  assign rob_dec_if.ins1       = slot1_q.ins;
  assign rob_dec_if.PC1        = slot1_q.pc;
  assign rob_dec_if.ins2_valid = ins2_valid_q;
  assign rob_dec_if.ins2       = slot2_q.ins;
  assign rob_dec_if.PC2        = slot2_q.pc;
  assign q_count               = w_count;
endmodule
`default_nettype wire

// File: tb/tb_dec_dispatch.sv
`default_nettype none
// tb_dec_dispatch : directed stimulus with an in-order scoreboard on the ROB interface.
module tb_dec_dispatch;
  import dec_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        f_valid1 = 1'b0, f_valid2 = 1'b0;
  logic [31:0] f_ins1 = '0, f_pc1 = '0, f_ins2 = '0, f_pc2 = '0;
  logic        f_ready;
  logic [1:0]  rob_retire_cnt = 2'd0;
  logic [3:0]  q_count;

  always #5 clk = ~clk;

  ifc_rob_dec #(.INS(32)) u_if ();

  dec_dispatch #(.INS(32), .QDEPTH(8), .ROB_DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .f_valid1       (f_valid1),
    .f_ins1         (f_ins1),
    .f_pc1          (f_pc1),
    .f_valid2       (f_valid2),
    .f_ins2         (f_ins2),
    .f_pc2          (f_pc2),
    .f_ready        (f_ready),
    .rob_retire_cnt (rob_retire_cnt),
    .rob_dec_if     (u_if),
    .q_count        (q_count)
  );

  int         checks = 0;
  int         errors = 0;
  int         last_cnt = 0;
  int         issued = 0;
  int         base;
  ins_entry_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_slot(input string nm, input logic v, input logic [63:0] got);
    ins_entry_t e;
    if (v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected: got %0h expected nothing", nm, got);
      end else begin
        e = exp_q.pop_front();
        chk(nm, got, 64'(e));
      end
    end else begin
      chk({nm, "_idle_data"}, got, 64'h0);
    end
  endtask

  // Monitor: scores every dispatched instruction in program order.
  always @(negedge clk) begin
    if (!rst) begin
      last_cnt = int'(u_if.ins1_valid) + int'(u_if.ins2_valid);
      issued  += last_cnt;
      chk("slot_order", {63'b0, u_if.ins2_valid & ~u_if.ins1_valid}, 64'h0);
      check_slot("slot1", u_if.ins1_valid, {u_if.ins1, u_if.PC1});
      check_slot("slot2", u_if.ins2_valid, {u_if.ins2, u_if.PC2});
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    f_valid1 = 1'b0; f_valid2 = 1'b0;
    f_ins1 = '0; f_pc1 = '0; f_ins2 = '0; f_pc2 = '0;
  endtask

  task automatic push(input logic v1, input logic [31:0] i1, input logic [31:0] p1,
                      input logic v2, input logic [31:0] i2, input logic [31:0] p2,
                      input bit exp_acc);
    f_valid1 = v1; f_ins1 = i1; f_pc1 = p1;
    f_valid2 = v2; f_ins2 = i2; f_pc2 = p2;
    if (exp_acc && v1) begin
      exp_q.push_back({i1, p1});
      if (v2) exp_q.push_back({i2, p2});
    end
    cyc();
    idle();
  endtask

  task automatic push_ten_pairs(input string nm, input int tag);
    base = issued;
    for (int k = 0; k < 10; k++) begin
      chk({nm, "_f_ready"}, {63'b0, f_ready}, 64'h1);
      push(1'b1, 32'(tag + 2*k), 32'(tag*4 + 8*k), 1'b1, 32'(tag + 2*k + 1), 32'(tag*4 + 8*k + 4), 1'b1);
    end
    repeat (4) cyc();
    chk({nm, "_issued"}, 64'(issued - base), 64'd16);
    chk({nm, "_q_count"}, 64'(q_count), 64'd4);
    chk({nm, "_quiet"}, 64'(last_cnt), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_t2[7] = '{0, 1, 1, 1, 1, 1, 0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_q_count", 64'(q_count), 64'd0);
    chk("rst_ins1_valid", {63'b0, u_if.ins1_valid}, 64'd0);
    chk("rst_ins2_valid", {63'b0, u_if.ins2_valid}, 64'd0);
    rst = 1'b0;
    #1;
    chk("f_ready_after_rst", {63'b0, f_ready}, 64'd1);

    // Single pair: one edge of queue latency, then both slots together.
    push(1'b1, 32'h11, 32'h100, 1'b1, 32'h22, 32'h104, 1'b1);
    chk("t1_no_bypass", 64'(last_cnt), 64'd0);
    chk("t1_q_count", 64'(q_count), 64'd2);
    cyc();
    chk("t1_dispatch", 64'(last_cnt), 64'd2);
    cyc();
    chk("t1_after", 64'(last_cnt), 64'd0);
    chk("t1_q_empty", 64'(q_count), 64'd0);

    // Slot 2 without slot 1 must be dropped.
    push(1'b0, 32'h0, 32'h0, 1'b1, 32'hdead, 32'hbeef, 1'b0);
    chk("lone_slot2_q", 64'(q_count), 64'd0);
    cyc();
    chk("lone_slot2_issue", 64'(last_cnt), 64'd0);

    // Five back-to-back singles drain one per cycle, in order.
    for (int i = 0; i < 7; i++) begin
      if (i < 5) push(1'b1, 32'(8'hA0 + i), 32'(32'h200 + 4*i), 1'b0, '0, '0, 1'b1);
      else cyc();
      chk("t2_per_cycle", 64'(last_cnt), 64'(exp_t2[i]));
    end
    chk("t2_q_empty", 64'(q_count), 64'd0);

    // Return the 7 outstanding credits.
    rob_retire_cnt = 2'd2; cyc(); cyc(); cyc();
    rob_retire_cnt = 2'd1; cyc();
    rob_retire_cnt = 2'd0;

    // Credit exhaustion: 20 pushed, exactly 16 dispatched.
    push_ten_pairs("t3", 32'h1000);
    rob_retire_cnt = 2'd1; cyc();
    rob_retire_cnt = 2'd0;
    chk("t3_retire_edge", 64'(last_cnt), 64'd0);
    cyc();
    chk("t3_one_more", 64'(last_cnt), 64'd1);
    chk("t3_slot2_idle", {63'b0, u_if.ins2_valid}, 64'd0);
    cyc();
    chk("t3_quiet_again", 64'(last_cnt), 64'd0);
    chk("t3_q_count", 64'(q_count), 64'd3);

    // Fill to QDEPTH with no credits.
    chk("t4_ready_a", {63'b0, f_ready}, 64'd1);
    push(1'b1, 32'h500, 32'h5000, 1'b0, '0, '0, 1'b1);
    chk("t4_ready_b", {63'b0, f_ready}, 64'd1);
    push(1'b1, 32'h501, 32'h5004, 1'b1, 32'h502, 32'h5008, 1'b1);
    chk("t4_ready_c", {63'b0, f_ready}, 64'd1);
    push(1'b1, 32'h503, 32'h500c, 1'b1, 32'h504, 32'h5010, 1'b1);
    chk("t4_full_q", 64'(q_count), 64'd8);
    chk("t4_full_ready", {63'b0, f_ready}, 64'd0);
    push(1'b1, 32'h5ff, 32'h5ff0, 1'b1, 32'h5fe, 32'h5ff4, 1'b0);
    chk("t4_ignored_q", 64'(q_count), 64'd8);
    chk("t4_ignored_issue", 64'(last_cnt), 64'd0);

    // Drain two, then flush with a pair presented.
    rob_retire_cnt = 2'd2; cyc();
    rob_retire_cnt = 2'd0; cyc();
    chk("t5_pre_issue", 64'(last_cnt), 64'd2);
    chk("t5_pre_q", 64'(q_count), 64'd6);
    flush = 1'b1;
    push(1'b1, 32'h777, 32'h7770, 1'b1, 32'h778, 32'h7774, 1'b0);
    flush = 1'b0;
    exp_q.delete();
    chk("t5_flush_q", 64'(q_count), 64'd0);
    chk("t5_flush_issue", 64'(last_cnt), 64'd0);
    cyc();
    chk("t5_no_ghost", 64'(last_cnt), 64'd0);
    chk("t5_q_still_empty", 64'(q_count), 64'd0);
    push_ten_pairs("t5_credits", 32'h2000);

    // Async reset while both slots are valid.
    rob_retire_cnt = 2'd2; cyc();
    rob_retire_cnt = 2'd0; cyc();
    chk("t6_pre_issue", 64'(last_cnt), 64'd2);
    rst = 1'b1;
    #1;
    chk("t6_async_v1", {63'b0, u_if.ins1_valid}, 64'd0);
    chk("t6_async_v2", {63'b0, u_if.ins2_valid}, 64'd0);
    chk("t6_async_data", {u_if.ins1, u_if.PC1}, 64'd0);
    chk("t6_async_q", 64'(q_count), 64'd0);
    exp_q.delete();
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_ready", {63'b0, f_ready}, 64'd1);
    push(1'b1, 32'h33, 32'h300, 1'b1, 32'h44, 32'h304, 1'b1);
    chk("t6_latency", 64'(last_cnt), 64'd0);
    cyc();
    chk("t6_issue", 64'(last_cnt), 64'd2);
    cyc();
    chk("t6_q_empty", 64'(q_count), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
